// File: rtl/l2_pkg.sv
// Shared definitions for the L2 memory responder: FSM state encoding,
// default geometry and the block-index decode used on incoming addresses.
package l2_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_BUSY = 3'd1,
        RD_BUSY = 3'd2,
        WR_DONE = 3'd3,
        RD_DONE = 3'd4
    } l2_state_t;

    localparam int unsigned L2_BLOCK_BITS = 128;
    localparam int unsigned L2_DEPTH_LOG2 = 8;

    // Drops the byte offset within a block, then keeps DEPTH_LOG2 index bits.
    // Anything above the index is discarded, so those addresses alias.
    function automatic logic [31:0] blk_index(
        input logic [63:0] addr,
        input int unsigned block_bits = L2_BLOCK_BITS,
        input int unsigned depth_log2 = L2_DEPTH_LOG2
    );
        logic [63:0] shifted;
        logic [63:0] mask;
        shifted = addr >> $clog2(block_bits / 8);
        mask    = (64'd1 << depth_log2) - 64'd1;
        return 32'(shifted & mask);
    endfunction

endpackage

// File: rtl/l2_block_ram.sv
// Single-port block store for the L2 responder. One block per index,
// synchronous write, registered read that holds until the next read enable.
module l2_block_ram
    import l2_pkg::*;
#(
    parameter int unsigned BLOCK_BITS = L2_BLOCK_BITS,
    parameter int unsigned DEPTH_LOG2 = L2_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [BLOCK_BITS-1:0] wdata,
    output logic [BLOCK_BITS-1:0] rdata
);

    logic [BLOCK_BITS-1:0] mem [1 << DEPTH_LOG2];
    logic [BLOCK_BITS-1:0] rdata_d;
    logic [BLOCK_BITS-1:0] rdata_q;

    // Next read register value: capture the addressed block only when asked.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[idx];
        end
    end

    // Array write port.
    // NOTE: the storage array has no reset; clearing it would cost a reset
    // fan-out to every bit and the contents must survive reset anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read data register, cleared on reset so the fill bus starts at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/l2_mem_responder.sv
// Responder side of the L1<->L2 miss interface. Accepts write-back and fill
// requests, waits LATENCY busy cycles, then issues a one-cycle completion
// pulse (write_done / l2_ack). Fill data is valid in the l2_ack cycle.
// Optional build macro: L2_STATS_EN adds saturating rd_count / wr_count.
module l2_mem_responder
    import l2_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned BLOCK_BITS = L2_BLOCK_BITS,
    parameter int unsigned DEPTH_LOG2 = L2_DEPTH_LOG2,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_l2,
    input  logic                  write_l2,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [BLOCK_BITS-1:0] wdata,
    output logic                  l2_ack,
    output logic                  write_done,
    output logic [BLOCK_BITS-1:0] rdata,
    output logic                  busy
`ifdef L2_STATS_EN
    ,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
`endif
);

    localparam int unsigned    CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    l2_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [BLOCK_BITS-1:0] wdata_q, wdata_d;
    logic                  last_beat;
    logic                  ram_we;
    logic                  ram_re;

    // FSM next state, latency counter and request capture.
    // NOTE: every variable gets a default at the top of the block so that no
    // path through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        ram_re    = 1'b0;
        last_beat = (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                // Write-back wins over a simultaneous fill so the victim
                // reaches memory before the allocate reads it.
                if (write_l2) begin
                    idx_d   = DEPTH_LOG2'(blk_index(64'(addr), BLOCK_BITS, DEPTH_LOG2));
                    wdata_d = wdata;
                    cnt_d   = '0;
                    state_d = WR_BUSY;
                end else if (read_l2) begin
                    idx_d   = DEPTH_LOG2'(blk_index(64'(addr), BLOCK_BITS, DEPTH_LOG2));
                    cnt_d   = '0;
                    state_d = RD_BUSY;
                end
            end
            WR_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!write_l2) begin
                    state_d = IDLE;
                end else if (last_beat) begin
                    state_d = WR_DONE;
                end
            end
            RD_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!read_l2) begin
                    state_d = IDLE;
                end else if (last_beat) begin
                    // Read the block one cycle early so the registered data
                    // lines up with the l2_ack pulse.
                    ram_re  = 1'b1;
                    state_d = RD_DONE;
                end
            end
            WR_DONE: state_d = IDLE;
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and request registers.
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    // Memory commits only in WR_DONE, so an abort or reset before then
    // leaves the block untouched.
    assign ram_we = (state_q == WR_DONE);

    l2_block_ram #(
        .BLOCK_BITS (BLOCK_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign write_done = (state_q == WR_DONE);
    assign l2_ack     = (state_q == RD_DONE);
    assign busy       = (state_q != IDLE);

`ifdef L2_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    // Saturating completion counters.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == RD_DONE && rd_count_q != 16'hFFFF) begin
            rd_count_d = rd_count_q + 16'd1;
        end
        if (state_q == WR_DONE && wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_l2_mem_responder.sv
// Self-checking bench for l2_mem_responder. Fill data is checked through a
// scoreboard: expected blocks are queued when a fill is issued and compared
// by a monitor whenever l2_ack pulses.
module tb_l2_mem_responder;

    localparam int AW  = 32;
    localparam int BB  = 128;
    localparam int DL  = 8;
    localparam int LAT = 4;

    // Pulse expected only in cycle LAT+1; busy in cycles 1..LAT+1.
    localparam logic [15:0] PULSE_M = 16'h0001 << (LAT + 1);
    localparam logic [15:0] BUSY_M  = ((16'h0001 << (LAT + 2)) - 16'h0001) & 16'hFFFE;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          read_l2;
    logic          write_l2;
    logic [AW-1:0] addr;
    logic [BB-1:0] wdata;
    logic          l2_ack;
    logic          write_done;
    logic [BB-1:0] rdata;
    logic          busy;
`ifdef L2_STATS_EN
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [BB-1:0] model [int];
    logic [BB-1:0] exp_q [$];

    l2_mem_responder #(
        .ADDR_W     (AW),
        .BLOCK_BITS (BB),
        .DEPTH_LOG2 (DL),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .read_l2    (read_l2),
        .write_l2   (write_l2),
        .addr       (addr),
        .wdata      (wdata),
        .l2_ack     (l2_ack),
        .write_done (write_done),
        .rdata      (rdata),
        .busy       (busy)
`ifdef L2_STATS_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic int tb_idx(input logic [31:0] a);
        return int'((a >> 4) & 32'h0000_00FF);
    endfunction

    // Scoreboard monitor: every fill completion pops one expected block.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && l2_ack === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_ack: rdata=%h with no fill outstanding", rdata);
            end else begin
                logic [BB-1:0] e;
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    bad++;
                    $display("FAIL sb_fill_data: got=%h exp=%h", rdata, e);
                end
            end
        end
    end

    task automatic apply_reset();
        write_l2 = 1'b0;
        read_l2  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one request from the current negedge (cycle 0) and records which
    // cycles showed each output; the request drops on the pulse or at drop_at.
    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [BB-1:0] d, input int drop_at,
                           output logic [15:0] ack_m, output logic [15:0] done_m,
                           output logic [15:0] busy_m);
        ack_m = '0; done_m = '0; busy_m = '0;
        addr = a; wdata = d; write_l2 = wr; read_l2 = rd;
        for (int c = 1; c <= LAT + 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (l2_ack === 1'b1)     ack_m[c]  = 1'b1;
            if (write_done === 1'b1) done_m[c] = 1'b1;
            if (busy === 1'b1)       busy_m[c] = 1'b1;
            if (l2_ack === 1'b1 || write_done === 1'b1 || c == drop_at) begin
                write_l2 = 1'b0;
                read_l2  = 1'b0;
            end
            // Scramble the bus while busy; the latched request must be used.
            if (c == 1) begin
                addr  = $urandom;
                wdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    endtask

    task automatic test_reset();
        write_l2 = 1'b0; read_l2 = 1'b0; addr = '0; wdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, l2_ack, write_done} !== 3'b000 || rdata !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy/ack/done=%b rdata=%h exp 000/0",
                     {busy, l2_ack, write_done}, rdata);
        end
`ifdef L2_STATS_EN
        total++;
        if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_counts: rd=%0d wr=%0d exp 0/0", rd_count, wr_count);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_latency();
        logic [15:0] am, dm, bm;
        logic [BB-1:0] d;
        d = {16{8'hA5}};
        run_txn(1'b1, 1'b0, 32'h0000_0120, d, 0, am, dm, bm);
        total++;
        if (dm !== PULSE_M) begin
            bad++;
            $display("FAIL wr_done_timing: cycles=%b exp=%b", dm, PULSE_M);
        end
        total++;
        if (am !== 16'h0) begin
            bad++;
            $display("FAIL wr_no_ack: cycles=%b exp=0", am);
        end
        total++;
        if (bm !== BUSY_M) begin
            bad++;
            $display("FAIL wr_busy: cycles=%b exp=%b", bm, BUSY_M);
        end
        model[tb_idx(32'h0000_0120)] = d;
    endtask

    task automatic test_read();
        logic [15:0] am, dm, bm;
        exp_q.push_back(model[tb_idx(32'h0000_0120)]);
        run_txn(1'b0, 1'b1, 32'h0000_0120, '0, 0, am, dm, bm);
        total++;
        if (am !== PULSE_M) begin
            bad++;
            $display("FAIL rd_ack_timing: cycles=%b exp=%b", am, PULSE_M);
        end
        total++;
        if (dm !== 16'h0 || bm !== BUSY_M) begin
            bad++;
            $display("FAIL rd_done_busy: done=%b busy=%b exp 0/%b", dm, bm, BUSY_M);
        end
        repeat (3) @(negedge clk);
        total++;
        if (rdata !== {16{8'hA5}}) begin
            bad++;
            $display("FAIL rd_hold: rdata=%h exp=%h", rdata, {16{8'hA5}});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] am, dm, bm;
        int wd_cyc, ack_cyc;
        logic [BB-1:0] dw;
        dw = {16{8'hC3}};
        run_txn(1'b1, 1'b0, 32'h0000_0080, dw, 0, am, dm, bm);
        model[tb_idx(32'h0000_0080)] = dw;
        exp_q.push_back(dw);
        wd_cyc = -1; ack_cyc = -1;
        addr = 32'h0000_0040; wdata = {16{8'h5A}};
        write_l2 = 1'b1; read_l2 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (write_done === 1'b1 && wd_cyc < 0) begin
                wd_cyc   = c;
                write_l2 = 1'b0;
                addr     = 32'h0000_0080;
            end
            if (l2_ack === 1'b1 && ack_cyc < 0) begin
                ack_cyc = c;
                read_l2 = 1'b0;
            end
        end
        write_l2 = 1'b0; read_l2 = 1'b0;
        model[tb_idx(32'h0000_0040)] = {16{8'h5A}};
        total++;
        if (wd_cyc !== LAT + 1) begin
            bad++;
            $display("FAIL both_write_first: write_done cycle=%0d exp=%0d", wd_cyc, LAT + 1);
        end
        total++;
        if (ack_cyc !== 2 * LAT + 3) begin
            bad++;
            $display("FAIL both_read_after: l2_ack cycle=%0d exp=%0d", ack_cyc, 2 * LAT + 3);
        end
    endtask

    task automatic test_abort();
        logic [15:0] am, dm, bm;
        logic [BB-1:0] prior;
        prior = rdata;
        run_txn(1'b0, 1'b1, 32'h0000_0120, '0, 2, am, dm, bm);
        total++;
        if (am !== 16'h0 || bm !== 16'h0006) begin
            bad++;
            $display("FAIL rd_abort: ack=%b busy=%b exp 0/0006", am, bm);
        end
        total++;
        if (rdata !== prior) begin
            bad++;
            $display("FAIL rd_abort_rdata: rdata=%h exp=%h", rdata, prior);
        end
        run_txn(1'b1, 1'b0, 32'h0000_0040, {16{8'hEE}}, 2, am, dm, bm);
        total++;
        if (dm !== 16'h0 || bm !== 16'h0006) begin
            bad++;
            $display("FAIL wr_abort: done=%b busy=%b exp 0/0006", dm, bm);
        end
        // Block must still hold the committed 5A pattern.
        exp_q.push_back(model[tb_idx(32'h0000_0040)]);
        run_txn(1'b0, 1'b1, 32'h0000_0040, '0, 0, am, dm, bm);
        total++;
        if (am !== PULSE_M) begin
            bad++;
            $display("FAIL wr_abort_readback_ack: cycles=%b exp=%b", am, PULSE_M);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] am, dm, bm;
        addr = 32'h0000_0120; wdata = {8{16'h1111}};
        write_l2 = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, l2_ack, write_done} !== 3'b000 || rdata !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: busy/ack/done=%b rdata=%h exp 000/0",
                     {busy, l2_ack, write_done}, rdata);
        end
        write_l2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(model[tb_idx(32'h0000_0120)]);
        run_txn(1'b0, 1'b1, 32'h0000_0120, '0, 0, am, dm, bm);
        total++;
        if (am !== PULSE_M) begin
            bad++;
            $display("FAIL mid_reset_readback_ack: cycles=%b exp=%b", am, PULSE_M);
        end
    endtask

    task automatic test_alias();
        logic [15:0] am, dm, bm;
        logic [BB-1:0] d;
        d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(1'b1, 1'b0, 32'h0000_0010, d, 0, am, dm, bm);
        total++;
        if (dm !== PULSE_M) begin
            bad++;
            $display("FAIL alias_write: cycles=%b exp=%b", dm, PULSE_M);
        end
        exp_q.push_back(d);
        run_txn(1'b0, 1'b1, 32'h8000_0010, '0, 0, am, dm, bm);
        total++;
        if (am !== PULSE_M) begin
            bad++;
            $display("FAIL alias_read_ack: cycles=%b exp=%b", am, PULSE_M);
        end
`ifdef L2_STATS_EN
        total++;
        if (rd_count !== 16'd1 || wr_count !== 16'd1) begin
            bad++;
            $display("FAIL alias_counts: rd=%0d wr=%0d exp 1/1", rd_count, wr_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_read();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_alias();
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d fills never acknowledged, exp 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
